mr1_bus_arbiter: RTL and testbench
==================================

Name: mr1_bus_arbiter

Overview:
- Shares one memory port between the MR1 instruction bus (iBus) and data bus (dBus).
- Arbitrates command phases between the two buses.
- Tracks the source of each outstanding read and routes in-order memory responses back to the requester that issued them.
- Sits between the MR1 core and its memory or formal harness. The iBus/dBus-facing signals keep the core's existing handshake semantics.

Parameters:
MAX_PENDING, 2, maximum outstanding reads (depth of source-tag FIFO), >=1
STARVE_LIMIT, 4, consecutive dBus command grants allowed while iBus waits before iBus is forced, >=1

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
ibus_cmd_valid  in  1  iBus fetch request
ibus_cmd_ready  out  1  iBus command accepted this cycle
ibus_cmd_payload_pc  in  32  fetch address
ibus_rsp_ready  out  1  iBus response valid (single-cycle pulse)
ibus_rsp_inst  out  32  fetched instruction
ibus_rsp_error  out  1  fetch error
dbus_cmd_valid  in  1  dBus request
dbus_cmd_ready  out  1  dBus command accepted this cycle
dbus_cmd_payload_wr  in  1  1=store, 0=load
dbus_cmd_payload_address  in  32  data address
dbus_cmd_payload_data  in  32  store data
dbus_cmd_payload_size  in  2  0=byte, 1=half, 2=word
dbus_rsp_ready  out  1  dBus load response valid (pulse)
dbus_rsp_data  out  32  load data
dbus_rsp_error  out  1  load error
mem_cmd_valid  out  1  memory command valid
mem_cmd_ready  in  1  memory accepts command
mem_cmd_payload_wr  out  1  write flag (0 for iBus)
mem_cmd_payload_address  out  32  address
mem_cmd_payload_data  out  32  write data (0 for iBus)
mem_cmd_payload_size  out  2  size (2 for iBus)
mem_rsp_valid  in  1  read response valid, strictly in command order
mem_rsp_data  in  32  read data
mem_rsp_error  in  1  read error
protocol_error  out  1  sticky: response received with no read outstanding

Behaviour:
- Reset (reset_n low, asynchronous): tag FIFO empty, pending count 0, starve counter 0, lock cleared, protocol_error 0.
  - All valid/ready outputs are 0 during and immediately after reset.
- Command transfer: occurs when mem_cmd_valid && mem_cmd_ready.
  - ibus_cmd_ready = mem_cmd_ready && grant==I && !blocked.
  - dbus_cmd_ready = mem_cmd_ready && grant==D && !blocked.
  - mem_cmd_* are combinational muxes of the granted source, zero latency.
- blocked = (pending == MAX_PENDING).
  - When blocked, mem_cmd_valid = 0, including for stores. This keeps ordering simple.
  - A same-cycle pop does not unblock.
- Arbitration states are IDLE, LOCK_I and LOCK_D:
  - IDLE: grant D if dbus_cmd_valid and (starve < STARVE_LIMIT or !ibus_cmd_valid); otherwise grant I if ibus_cmd_valid.
  - If the granted command is presented and not accepted, the next state is LOCK_x. Grant is held and cannot switch until transfer.
  - LOCK_x returns to IDLE on transfer.
  - If the locked source drops valid (protocol violation), return to IDLE.
- Starve counter, saturating at STARVE_LIMIT:
  - +1 on each dBus transfer while ibus_cmd_valid.
  - Cleared on iBus transfer or when ibus_cmd_valid = 0.
- Tag FIFO, 1 bit per entry (0=I, 1=D), depth MAX_PENDING, circular pointers with wrap:
  - Push on a read transfer (iBus, or dBus with wr = 0).
  - Pop on mem_rsp_valid.
  - Push and pop in the same cycle leave pending unchanged.
- Response routing:
  - When mem_rsp_valid and the FIFO is not empty, pulse ibus_rsp_ready or dbus_rsp_ready per the head tag, the same cycle (combinational).
  - Data and error are passed through to both buses. rsp_* data outputs are don't-care when the pulse is low.
- Stores produce no response and are never pushed.
- mem_rsp_valid with an empty FIFO: response dropped, no pulse, protocol_error set until reset.
- Reset mid-transaction: outstanding tags are discarded. Late memory responses then set protocol_error.

Test Plan:
- iBus-only, mem_cmd_ready=1, pc=0x00000000,0x04 -> two transfers; responses 0x00000013 then 0x00100093 pulse ibus_rsp_ready only; pending returns to 0.
- Simultaneous ibus/dbus valid, dbus continuously valid (loads), STARVE_LIMIT=4 -> grants D,D,D,D,I repeating; every iBus request is accepted within 5 transfers.
- dBus load to 0x80 stalled with mem_cmd_ready=0 for 3 cycles while iBus raises valid -> address stays 0x80 and grant stays D until transfer, then iBus is granted.
- Fill MAX_PENDING=2 reads (I then D) with no responses -> mem_cmd_valid=0; responses 0xAAAA/0xBBBB go to iBus then dBus in order; issue resumes.
- dBus store (wr=1, size=0, data=0xFF) with FIFO holding one iBus read -> no dBus response; the next mem_rsp goes to iBus.
- mem_rsp_valid with nothing pending -> no rsp pulse, protocol_error=1 and held; an async reset_n assertion clears it immediately.

Source files
------------

// File: rtl/mr1_bus_arbiter.sv
// MR1 iBus/dBus arbiter onto a single in-order memory port.
// Read responses are steered back to their issuer by a source-tag FIFO.
module mr1_bus_arbiter #(
    parameter int MAX_PENDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ibus_cmd_valid,
    output logic        ibus_cmd_ready,
    input  logic [31:0] ibus_cmd_payload_pc,
    output logic        ibus_rsp_ready,
    output logic [31:0] ibus_rsp_inst,
    output logic        ibus_rsp_error,
    input  logic        dbus_cmd_valid,
    output logic        dbus_cmd_ready,
    input  logic        dbus_cmd_payload_wr,
    input  logic [31:0] dbus_cmd_payload_address,
    input  logic [31:0] dbus_cmd_payload_data,
    input  logic [1:0]  dbus_cmd_payload_size,
    output logic        dbus_rsp_ready,
    output logic [31:0] dbus_rsp_data,
    output logic        dbus_rsp_error,
    output logic        mem_cmd_valid,
    input  logic        mem_cmd_ready,
    output logic        mem_cmd_payload_wr,
    output logic [31:0] mem_cmd_payload_address,
    output logic [31:0] mem_cmd_payload_data,
    output logic [1:0]  mem_cmd_payload_size,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_error,
    output logic        protocol_error
);

    localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} arbState_e;

    arbState_e state, nextState;
    logic [MAX_PENDING-1:0] tags;
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] pending;
    logic [SW-1:0] starve;
    logic protocolErr;

    logic grantI, grantD, blocked, xfer, push, pop, empty, headTag;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(MAX_PENDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        grantI = 1'b0;
        grantD = 1'b0;
        // A lock whose source dropped valid falls back to fresh arbitration
        if (state == LOCK_I && ibus_cmd_valid)
            grantI = 1'b1;
        else if (state == LOCK_D && dbus_cmd_valid)
            grantD = 1'b1;
        else if (dbus_cmd_valid &&
                 (starve < SW'(STARVE_LIMIT) || !ibus_cmd_valid))
            grantD = 1'b1;
        else if (ibus_cmd_valid)
            grantI = 1'b1;
    end

    assign blocked = (pending == CW'(MAX_PENDING));
    assign empty   = (pending == '0);
    assign mem_cmd_valid = reset_n && !blocked && (grantI || grantD);
    assign xfer    = mem_cmd_valid && mem_cmd_ready;
    assign ibus_cmd_ready = xfer && grantI;
    assign dbus_cmd_ready = xfer && grantD;
    assign push    = xfer && (grantI || !dbus_cmd_payload_wr);
    assign pop     = mem_rsp_valid && !empty;
    assign headTag = tags[rdPtr];

    always_comb begin
        nextState = IDLE;
        if (mem_cmd_valid && !mem_cmd_ready)
            nextState = grantD ? LOCK_D : LOCK_I;
    end

    always_comb begin
        mem_cmd_payload_wr      = 1'b0;
        mem_cmd_payload_address = ibus_cmd_payload_pc;
        mem_cmd_payload_data    = '0;
        mem_cmd_payload_size    = 2'd2;
        if (grantD) begin
            mem_cmd_payload_wr      = dbus_cmd_payload_wr;
            mem_cmd_payload_address = dbus_cmd_payload_address;
            mem_cmd_payload_data    = dbus_cmd_payload_data;
            mem_cmd_payload_size    = dbus_cmd_payload_size;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tags        <= '0;
            wrPtr       <= '0;
            rdPtr       <= '0;
            pending     <= '0;
            starve      <= '0;
            protocolErr <= 1'b0;
        end else begin
            state <= nextState;
            if (push) begin
                tags[wrPtr] <= grantD;
                wrPtr       <= nextPtr(wrPtr);
            end
            if (pop)
                rdPtr <= nextPtr(rdPtr);
            if (push && !pop)
                pending <= pending + 1'b1;
            else if (pop && !push)
                pending <= pending - 1'b1;
            if (!ibus_cmd_valid || ibus_cmd_ready)
                starve <= '0;
            else if (dbus_cmd_ready && starve < SW'(STARVE_LIMIT))
                starve <= starve + 1'b1;
            if (mem_rsp_valid && empty)
                protocolErr <= 1'b1;
        end
    end

    assign ibus_rsp_ready = pop && !headTag;
    assign dbus_rsp_ready = pop && headTag;
    assign ibus_rsp_inst  = mem_rsp_data;
    assign ibus_rsp_error = mem_rsp_error;
    assign dbus_rsp_data  = mem_rsp_data;
    assign dbus_rsp_error = mem_rsp_error;
    assign protocol_error = protocolErr;

endmodule

// File: tb/tb_mr1_bus_arbiter.sv
// Directed bench for mr1_bus_arbiter: arbitration, locking,
// tag routing, backpressure and protocol-error handling.
module tb_mr1_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ibusCmdValid = 1'b0;
    logic        ibusCmdReady;
    logic [31:0] ibusPc = '0;
    logic        ibusRspReady;
    logic [31:0] ibusRspInst;
    logic        ibusRspError;
    logic        dbusCmdValid = 1'b0;
    logic        dbusCmdReady;
    logic        dbusWr = 1'b0;
    logic [31:0] dbusAddr = '0;
    logic [31:0] dbusData = '0;
    logic [1:0]  dbusSize = '0;
    logic        dbusRspReady;
    logic [31:0] dbusRspData;
    logic        dbusRspError;
    logic        memCmdValid;
    logic        memCmdReady = 1'b0;
    logic        memWr;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic [1:0]  memSize;
    logic        memRspValid = 1'b0;
    logic [31:0] memRspData = '0;
    logic        memRspError = 1'b0;
    logic        protocolError;

    int checkCount = 0;
    int errorCount = 0;

    bit expD [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    mr1_bus_arbiter #(.MAX_PENDING(2), .STARVE_LIMIT(4)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .ibus_cmd_valid(ibusCmdValid),
        .ibus_cmd_ready(ibusCmdReady),
        .ibus_cmd_payload_pc(ibusPc),
        .ibus_rsp_ready(ibusRspReady),
        .ibus_rsp_inst(ibusRspInst),
        .ibus_rsp_error(ibusRspError),
        .dbus_cmd_valid(dbusCmdValid),
        .dbus_cmd_ready(dbusCmdReady),
        .dbus_cmd_payload_wr(dbusWr),
        .dbus_cmd_payload_address(dbusAddr),
        .dbus_cmd_payload_data(dbusData),
        .dbus_cmd_payload_size(dbusSize),
        .dbus_rsp_ready(dbusRspReady),
        .dbus_rsp_data(dbusRspData),
        .dbus_rsp_error(dbusRspError),
        .mem_cmd_valid(memCmdValid),
        .mem_cmd_ready(memCmdReady),
        .mem_cmd_payload_wr(memWr),
        .mem_cmd_payload_address(memAddr),
        .mem_cmd_payload_data(memData),
        .mem_cmd_payload_size(memSize),
        .mem_rsp_valid(memRspValid),
        .mem_rsp_data(memRspData),
        .mem_rsp_error(memRspError),
        .protocol_error(protocolError)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs;
        ibusCmdValid = 1'b0;
        dbusCmdValid = 1'b0;
        dbusWr = 1'b0;
        memCmdReady = 1'b1;
        memRspValid = 1'b0;
        memRspError = 1'b0;
    endtask

    initial begin
        // Outputs held quiet in reset even with active inputs
        ibusCmdValid = 1'b1;
        dbusCmdValid = 1'b1;
        memCmdReady = 1'b1;
        memRspValid = 1'b1;
        #3;
        check("rst_memvalid", memCmdValid, 0);
        check("rst_iready", ibusCmdReady, 0);
        check("rst_dready", dbusCmdReady, 0);
        check("rst_irsp", ibusRspReady, 0);
        check("rst_drsp", dbusRspReady, 0);
        step;
        step;
        check("rst_perr", protocolError, 0);
        idleInputs();
        reset_n = 1'b1;
        #1;
        check("post_rst_memvalid", memCmdValid, 0);
        step;
        check("post_rst_perr", protocolError, 0);

        // iBus-only fetches
        ibusCmdValid = 1'b1;
        ibusPc = 32'h0;
        #1;
        check("i0_valid", memCmdValid, 1);
        check("i0_ready", ibusCmdReady, 1);
        check("i0_addr", memAddr, 32'h0);
        check("i0_wr", memWr, 0);
        check("i0_size", memSize, 2);
        check("i0_data", memData, 0);
        step;
        ibusPc = 32'h4;
        #1;
        check("i1_ready", ibusCmdReady, 1);
        check("i1_addr", memAddr, 32'h4);
        step;
        ibusCmdValid = 1'b0;
        memRspValid = 1'b1;
        memRspData = 32'h00000013;
        #1;
        check("i0_rsp_i", ibusRspReady, 1);
        check("i0_rsp_d", dbusRspReady, 0);
        check("i0_inst", ibusRspInst, 32'h00000013);
        step;
        memRspData = 32'h00100093;
        #1;
        check("i1_rsp_i", ibusRspReady, 1);
        check("i1_rsp_d", dbusRspReady, 0);
        check("i1_inst", ibusRspInst, 32'h00100093);
        step;
        memRspValid = 1'b0;

        // Starvation: D,D,D,D,I repeating
        ibusCmdValid = 1'b1;
        ibusPc = 32'h200;
        dbusCmdValid = 1'b1;
        dbusWr = 1'b0;
        dbusAddr = 32'h100;
        for (int k = 0; k < 10; k++) begin
            memRspValid = (k > 0);
            memRspData = 32'(k);
            #1;
            check("starve_d", dbusCmdReady, expD[k]);
            check("starve_i", ibusCmdReady, !expD[k]);
            if (k > 0) begin
                check("starve_rsp_d", dbusRspReady, expD[k-1]);
                check("starve_rsp_i", ibusRspReady, !expD[k-1]);
            end
            step;
        end
        ibusCmdValid = 1'b0;
        dbusCmdValid = 1'b0;
        memRspValid = 1'b1;
        #1;
        check("starve_drain", ibusRspReady, 1);
        step;
        memRspValid = 1'b0;

        // dBus load stalled: grant held on D
        dbusCmdValid = 1'b1;
        dbusAddr = 32'h80;
        memCmdReady = 1'b0;
        #1;
        check("stall_valid", memCmdValid, 1);
        check("stall_addr0", memAddr, 32'h80);
        check("stall_dready0", dbusCmdReady, 0);
        step;
        for (int k = 0; k < 2; k++) begin
            ibusCmdValid = 1'b1;
            ibusPc = 32'h300;
            #1;
            check("stall_addr", memAddr, 32'h80);
            check("stall_iready", ibusCmdReady, 0);
            step;
        end
        memCmdReady = 1'b1;
        #1;
        check("stall_dxfer", dbusCmdReady, 1);
        check("stall_dxfer_addr", memAddr, 32'h80);
        step;
        dbusCmdValid = 1'b0;
        #1;
        check("stall_ixfer", ibusCmdReady, 1);
        check("stall_iaddr", memAddr, 32'h300);
        step;
        ibusCmdValid = 1'b0;
        memRspValid = 1'b1;
        memRspData = 32'h11;
        #1;
        check("stall_rsp_d", dbusRspReady, 1);
        check("stall_rsp_dnoti", ibusRspReady, 0);
        check("stall_rsp_data", dbusRspData, 32'h11);
        step;
        memRspData = 32'h22;
        #1;
        check("stall_rsp_i", ibusRspReady, 1);
        step;
        memRspValid = 1'b0;

        // Fill both slots, I then D
        ibusCmdValid = 1'b1;
        ibusPc = 32'h40;
        #1;
        check("fill_i", ibusCmdReady, 1);
        step;
        ibusCmdValid = 1'b0;
        dbusCmdValid = 1'b1;
        dbusAddr = 32'h44;
        #1;
        check("fill_d", dbusCmdReady, 1);
        step;
        ibusCmdValid = 1'b1;
        #1;
        check("full_valid", memCmdValid, 0);
        check("full_iready", ibusCmdReady, 0);
        check("full_dready", dbusCmdReady, 0);
        step;
        memRspValid = 1'b1;
        memRspData = 32'hAAAA;
        #1;
        check("full_rsp_i", ibusRspReady, 1);
        check("full_inst", ibusRspInst, 32'hAAAA);
        check("full_pop_blocked", memCmdValid, 0);
        step;
        ibusCmdValid = 1'b0;
        dbusCmdValid = 1'b0;
        memRspData = 32'hBBBB;
        #1;
        check("full_rsp_d", dbusRspReady, 1);
        check("full_rsp_dnoti", ibusRspReady, 0);
        check("full_data", dbusRspData, 32'hBBBB);
        step;
        memRspValid = 1'b0;

        // Store behind an outstanding fetch
        ibusCmdValid = 1'b1;
        ibusPc = 32'h50;
        #1;
        check("st_ifetch", ibusCmdReady, 1);
        step;
        ibusCmdValid = 1'b0;
        dbusCmdValid = 1'b1;
        dbusWr = 1'b1;
        dbusSize = 2'd0;
        dbusData = 32'hFF;
        dbusAddr = 32'h60;
        #1;
        check("st_valid", memCmdValid, 1);
        check("st_ready", dbusCmdReady, 1);
        check("st_wr", memWr, 1);
        check("st_size", memSize, 0);
        check("st_data", memData, 32'hFF);
        step;
        dbusCmdValid = 1'b0;
        dbusWr = 1'b0;
        memRspValid = 1'b1;
        memRspData = 32'h77;
        #1;
        check("st_rsp_i", ibusRspReady, 1);
        check("st_rsp_d", dbusRspReady, 0);
        step;
        memRspValid = 1'b0;

        // iBus lock holds off a newly valid dBus
        ibusCmdValid = 1'b1;
        ibusPc = 32'h90;
        memCmdReady = 1'b0;
        #1;
        check("li_addr0", memAddr, 32'h90);
        step;
        dbusCmdValid = 1'b1;
        dbusAddr = 32'hA0;
        #1;
        check("li_addr", memAddr, 32'h90);
        check("li_wr", memWr, 0);
        step;
        memCmdReady = 1'b1;
        #1;
        check("li_ixfer", ibusCmdReady, 1);
        check("li_dwait", dbusCmdReady, 0);
        step;
        ibusCmdValid = 1'b0;
        #1;
        check("li_dxfer", dbusCmdReady, 1);
        check("li_daddr", memAddr, 32'hA0);
        step;
        dbusCmdValid = 1'b0;
        memRspValid = 1'b1;
        memRspData = 32'h99;
        #1;
        check("li_rsp_i", ibusRspReady, 1);
        step;
        memRspData = 32'hA5;
        memRspError = 1'b1;
        #1;
        check("li_rsp_d", dbusRspReady, 1);
        check("li_rsp_err", dbusRspError, 1);
        step;
        memRspValid = 1'b0;
        memRspError = 1'b0;

        // Response with nothing outstanding
        memRspValid = 1'b1;
        memRspData = 32'h5;
        #1;
        check("perr_no_irsp", ibusRspReady, 0);
        check("perr_no_drsp", dbusRspReady, 0);
        step;
        memRspValid = 1'b0;
        #1;
        check("perr_set", protocolError, 1);
        step;
        check("perr_held", protocolError, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("perr_async_clr", protocolError, 0);
        step;
        reset_n = 1'b1;
        step;

        // Reset discards an outstanding tag
        ibusCmdValid = 1'b1;
        ibusPc = 32'h10;
        #1;
        check("mid_ifetch", ibusCmdReady, 1);
        step;
        ibusCmdValid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        step;
        memRspValid = 1'b1;
        #1;
        check("mid_no_rsp", ibusRspReady, 0);
        step;
        memRspValid = 1'b0;
        #1;
        check("mid_perr", protocolError, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checkCount, errorCount);
        $finish;
    end

endmodule
